// File: rtl/ddr3_pattern_tester.sv
// DDR3 traffic generator/checker for the Gowin DDR3 IP user port.
// Each pass writes NUM_BURSTS single-beat BL8 commands, reads them back and
// compares every returned beat in order. It keeps error/pass counters, a
// read timeout, and can loop passes continuously.
module ddr3_pattern_tester #(
    parameter int          ADDR_WIDTH     = 29,
    parameter int          APP_DATA_WIDTH = 256,
    parameter int          APP_MASK_WIDTH = 32,
    parameter int          NUM_BURSTS     = 1024,
    parameter int unsigned START_ADDR     = 0,
    parameter int unsigned ADDR_INC       = 8,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      continuous,
    input  logic                      stop,
    input  logic                      init_calib_complete,
    input  logic                      app_rdy,
    input  logic                      wr_data_rdy,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    output logic                      app_burst,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      timeout,
    output logic [15:0]               err_count,
    output logic [15:0]               pass_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr
);

    localparam int LANES = APP_DATA_WIDTH / 32;
    localparam int CNT_W = $clog2(NUM_BURSTS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]      NB_ALL  = CNT_W'(NUM_BURSTS);
    localparam logic [CNT_W-1:0]      NB_LAST = CNT_W'(NUM_BURSTS - 1);
    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] A_START = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_INC   = ADDR_WIDTH'(ADDR_INC);
    localparam logic [31:0]           POLY    = 32'h8020_0003;
    localparam logic [31:0]           SEED    = 32'hACE1_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_WRITE,
        S_READ,
        S_PASS,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]            mode_r;
    logic                  stop_lat;
    logic                  first_err_seen;

    logic [CNT_W-1:0]      wr_idx;
    logic [31:0]           wr_lfsr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic [CNT_W-1:0]      rd_cmd_cnt;
    logic [CNT_W-1:0]      rd_ret_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           ck_lfsr;
    logic [ADDR_WIDTH-1:0] ck_addr;
    logic [TO_W-1:0]       to_cnt;

    logic                  wr_accept;
    logic                  rd_cmd_accept;
    logic                  beat_accept;
    logic                  timeout_hit;
    logic                  mismatch;
    logic                  start_acc;
    logic                  enter_write;
    logic [15:0]           pass_seed_cnt;
    logic [31:0]           pass_seed;
    logic [APP_DATA_WIDTH-1:0] wr_pattern;
    logic [APP_DATA_WIDTH-1:0] ck_pattern;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        lfsr_next = (l >> 1) ^ (l[0] ? POLY : 32'h0);
    endfunction

    // Per-pass seed; an all-zero state would lock the LFSR, so map it to 1.
    function automatic logic [31:0] lfsr_seed(input logic [15:0] pc);
        logic [31:0] s;
        s = SEED ^ {16'h0, pc};
        lfsr_seed = (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] sh);
        rotl32 = (v << sh) | (v >> (6'd32 - {1'b0, sh}));
    endfunction

    // Full beat for index idx; l is the LFSR value belonging to that beat.
    function automatic logic [APP_DATA_WIDTH-1:0] gen_pattern(
        input logic [1:0]  m,
        input logic [31:0] idx,
        input logic [31:0] l
    );
        logic [APP_DATA_WIDTH-1:0] d;
        logic [31:0] base;
        logic [4:0]  sh;
        logic [4:0]  ws;
        d    = '0;
        base = idx * ADDR_INC;
        for (int k = 0; k < LANES; k++) begin
            sh = 5'(k);
            ws = idx[4:0] + sh;
            case (m)
                2'd0:    d[k*32 +: 32] = base + 32'(k);
                2'd1:    d[k*32 +: 32] = rotl32(l, sh);
                2'd2:    d[k*32 +: 32] = 32'h1 << ws;
                default: d[k*32 +: 32] = idx[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            endcase
        end
        gen_pattern = d;
    endfunction

    assign wr_pattern    = gen_pattern(mode_r, 32'(wr_idx), wr_lfsr);
    assign ck_pattern    = gen_pattern(mode_r, 32'(rd_ret_cnt), ck_lfsr);
    assign mismatch      = beat_accept && (app_rd_data != ck_pattern);
    assign start_acc     = (state == S_IDLE) && start;
    assign enter_write   = (next_state == S_WRITE) && (state != S_WRITE);
    assign pass_seed_cnt = (state == S_PASS) ? pass_count + 16'd1 : pass_count;
    assign pass_seed     = lfsr_seed(pass_seed_cnt);
    assign app_wdf_mask  = '0;
    assign app_burst     = 1'b1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic and the combinational user-port strobes.
    always_comb begin
        next_state    = state;
        wr_accept     = 1'b0;
        rd_cmd_accept = 1'b0;
        beat_accept   = 1'b0;
        timeout_hit   = 1'b0;
        app_en        = 1'b0;
        app_cmd       = 3'd0;
        app_addr      = '0;
        app_wdf_data  = '0;
        app_wdf_wren  = 1'b0;
        app_wdf_end   = 1'b0;
        busy          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                busy = 1'b1;
                if (init_calib_complete) next_state = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                app_addr     = wr_addr;
                app_wdf_data = wr_pattern;
                if (app_rdy && wr_data_rdy && (wr_idx < NB_ALL)) begin
                    wr_accept    = 1'b1;
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = 1'b1;
                    if (wr_idx == NB_LAST) next_state = S_READ;
                end
            end
            S_READ: begin
                busy          = 1'b1;
                app_cmd       = 3'd1;
                app_addr      = rd_addr;
                rd_cmd_accept = app_rdy && (rd_cmd_cnt < NB_ALL);
                app_en        = rd_cmd_accept;
                // A beat is only accepted against a command already issued
                // (or issued this very cycle), so outstanding never goes negative.
                beat_accept   = app_rd_data_valid &&
                                ((rd_ret_cnt < rd_cmd_cnt) || rd_cmd_accept);
                timeout_hit   = !rd_cmd_accept && !beat_accept &&
                                (rd_cmd_cnt != rd_ret_cnt) && (to_cnt == TO_LAST);
                if (timeout_hit)
                    next_state = S_DONE;
                else if (beat_accept && (rd_ret_cnt == NB_LAST))
                    next_state = S_PASS;
            end
            S_PASS: begin
                busy = 1'b1;
                if (continuous && !stop_lat && !stop) next_state = S_WRITE;
                else                                  next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Run status: mode capture, stop latch, sticky flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r         <= 2'd0;
            stop_lat       <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= 16'd0;
            pass_count     <= 16'd0;
            first_err_addr <= '0;
            first_err_seen <= 1'b0;
        end else if (start_acc) begin
            mode_r         <= mode;
            stop_lat       <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= 16'd0;
            pass_count     <= 16'd0;
            first_err_addr <= '0;
            first_err_seen <= 1'b0;
        end else begin
            if (stop)               stop_lat <= 1'b1;
            if (state == S_DONE)    done     <= 1'b1;
            if (state == S_PASS)    pass_count <= pass_count + 16'd1;
            if (timeout_hit) begin
                timeout <= 1'b1;
                error   <= 1'b1;
            end
            if (mismatch) begin
                error <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!first_err_seen) begin
                    first_err_addr <= ck_addr;
                    first_err_seen <= 1'b1;
                end
            end
        end
    end

    // Write-side generator: beat index, LFSR and address advance per accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_lfsr <= 32'h0;
            wr_addr <= '0;
        end else if (enter_write) begin
            wr_idx  <= '0;
            wr_lfsr <= pass_seed;
            wr_addr <= A_START;
        end else if (wr_accept) begin
            wr_idx  <= wr_idx + 1'b1;
            wr_lfsr <= lfsr_next(wr_lfsr);
            wr_addr <= wr_addr + A_INC;
        end
    end

    // Read-side: command counter/address, check generator and idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cmd_cnt <= '0;
            rd_ret_cnt <= '0;
            rd_addr    <= '0;
            ck_lfsr    <= 32'h0;
            ck_addr    <= '0;
            to_cnt     <= '0;
        end else if (enter_write) begin
            rd_cmd_cnt <= '0;
            rd_ret_cnt <= '0;
            rd_addr    <= A_START;
            ck_lfsr    <= pass_seed;
            ck_addr    <= A_START;
            to_cnt     <= '0;
        end else begin
            if (rd_cmd_accept) begin
                rd_cmd_cnt <= rd_cmd_cnt + 1'b1;
                rd_addr    <= rd_addr + A_INC;
            end
            if (beat_accept) begin
                rd_ret_cnt <= rd_ret_cnt + 1'b1;
                ck_lfsr    <= lfsr_next(ck_lfsr);
                ck_addr    <= ck_addr + A_INC;
            end
            if (state != S_READ || rd_cmd_accept || beat_accept ||
                rd_cmd_cnt == rd_ret_cnt)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule
